mem_stage_ctrl: RTL and testbench

//  LC-3b MEM-stage access controller; sits directly downstream of the EX/MEM pipeline register.

---
 rtl/mem_stage_ctrl_if.sv | 30 +++
 rtl/mem_stage_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - MEM-stage bundle: EX/MEM inputs, data-memory port, stall and WB result.
interface mem_stage_ctrl_if;
  logic        mem_valid;
  logic [15:0] mem_ir;
  logic [15:0] mem_address;
  logic [15:0] mem_store_data;
  logic        dmem_resp;
  logic [15:0] dmem_rdata;
  logic        dmem_read;
  logic        dmem_write;
  logic [15:0] dmem_addr;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic        stall;
  logic [15:0] wb_data;
  logic        wb_valid;
  logic        mem_error;

  modport master (
    input  mem_valid, mem_ir, mem_address, mem_store_data, dmem_resp, dmem_rdata,
    output dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byte_enable,
           stall, wb_data, wb_valid, mem_error
  );

  modport slave (
    output mem_valid, mem_ir, mem_address, mem_store_data, dmem_resp, dmem_rdata,
    input  dmem_read, dmem_write, dmem_addr, dmem_wdata, dmem_byte_enable,
           stall, wb_data, wb_valid, mem_error
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - LC-3b MEM-stage access controller (LDB/LDW/LDI/STB/STW/STI).
// Optional access timeout with sticky mem_error: define MEM_STAGE_TIMEOUT_EN.
module mem_stage_ctrl
`ifdef MEM_STAGE_TIMEOUT_EN
  #(parameter logic [7:0] TIMEOUT = 8'd255)
`endif
(
  input logic              clk,
  input logic              reset,
  mem_stage_ctrl_if.master bus
);
  localparam logic [3:0] OP_LDB = 4'b0010;
  localparam logic [3:0] OP_LDW = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STB = 4'b0011;
  localparam logic [3:0] OP_STW = 4'b0111;
  localparam logic [3:0] OP_STI = 4'b1011;

  typedef enum logic [1:0] {IDLE, ACCESS, INDIRECT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic [15:0] req_data_q, req_data_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic        wb_valid_q, wb_valid_d;

  logic        is_mem_opcode, mem_op;
  logic        op_ind, op_load, op_byte;
  logic        final_acc, resp_done, timeout;
  logic [15:0] word_addr, load_val;
  logic [7:0]  load_byte;

  always_comb begin
    is_mem_opcode = 1'b0;
    case (bus.mem_ir[15:12])
      OP_LDB, OP_LDW, OP_LDI, OP_STB, OP_STW, OP_STI: is_mem_opcode = 1'b1;
      default: is_mem_opcode = 1'b0;
    endcase
  end

  assign mem_op    = bus.mem_valid & is_mem_opcode;
  // Opcode encoding: bit3 marks indirection, bit0 marks a store, [3:2]==00 marks byte ops.
  assign op_ind    = op_q[3];
  assign op_load   = ~op_q[0];
  assign op_byte   = (op_q[3:2] == 2'b00);
  assign final_acc = ((state_q == ACCESS) & ~op_ind) | (state_q == INDIRECT);
  assign word_addr = {req_addr_q[15:1], 1'b0};
  assign load_byte = req_addr_q[0] ? bus.dmem_rdata[15:8] : bus.dmem_rdata[7:0];
  assign load_val  = op_byte ? {{8{load_byte[7]}}, load_byte} : bus.dmem_rdata;
  assign resp_done = bus.dmem_resp & ~timeout & (state_q != IDLE);

`ifdef MEM_STAGE_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;
  logic       mem_error_q;

  assign timeout       = (state_q != IDLE) && (wait_q == TIMEOUT);
  assign bus.mem_error = mem_error_q;

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)    wait_d = 8'd0;
    else if (state_q != IDLE)  wait_d = wait_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q      <= 8'd0;
      mem_error_q <= 1'b0;
    end else begin
      wait_q      <= wait_d;
      mem_error_q <= mem_error_q | timeout;
    end
  end
`else
  assign timeout       = 1'b0;
  assign bus.mem_error = 1'b0;
`endif

  assign bus.stall    = mem_op & ~(final_acc & bus.dmem_resp) & ~timeout;
  assign bus.wb_data  = wb_data_q;
  assign bus.wb_valid = wb_valid_q;

  always_comb begin
    bus.dmem_read        = 1'b0;
    bus.dmem_write       = 1'b0;
    bus.dmem_addr        = word_addr;
    bus.dmem_byte_enable = 2'b00;
    bus.dmem_wdata       = req_data_q;
    case (state_q)
      ACCESS: begin
        if (op_ind) begin
          bus.dmem_read        = 1'b1;
          bus.dmem_byte_enable = 2'b11;
        end else begin
          bus.dmem_read  = op_load;
          bus.dmem_write = ~op_load;
          if (op_byte) begin
            bus.dmem_addr        = req_addr_q;
            bus.dmem_byte_enable = req_addr_q[0] ? 2'b10 : 2'b01;
            bus.dmem_wdata       = {req_data_q[7:0], req_data_q[7:0]};
          end else begin
            bus.dmem_byte_enable = 2'b11;
          end
        end
      end
      INDIRECT: begin
        bus.dmem_read        = op_load;
        bus.dmem_write       = ~op_load;
        bus.dmem_byte_enable = 2'b11;
      end
      default: ;
    endcase
    if (timeout) begin
      bus.dmem_read  = 1'b0;
      bus.dmem_write = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    wb_data_d  = wb_data_q;
    wb_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          state_d    = ACCESS;
          op_d       = bus.mem_ir[15:12];
          req_addr_d = bus.mem_address;
          req_data_d = bus.mem_store_data;
        end
      end
      ACCESS: begin
        if (resp_done) begin
          if (op_ind) begin
            state_d    = INDIRECT;
            req_addr_d = bus.dmem_rdata;
          end else begin
            state_d = IDLE;
          end
        end
      end
      INDIRECT: if (resp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (resp_done & final_acc & op_load) begin
      wb_data_d  = load_val;
      wb_valid_d = 1'b1;
    end
    // An aborted load still retires so the pipeline never waits on a dead access.
    if (timeout) begin
      state_d = IDLE;
      if (op_load) begin
        wb_data_d  = 16'h0000;
        wb_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= 4'h0;
      req_addr_q <= 16'h0000;
      req_data_q <= 16'h0000;
      wb_data_q  <= 16'h0000;
      wb_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      wb_data_q  <= wb_data_d;
      wb_valid_q <= wb_valid_d;
    end
  end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - self-checking bench for mem_stage_ctrl.
module tb_mem_stage_ctrl;
  logic clk;
  logic reset;

  mem_stage_ctrl_if bus();

`ifdef MEM_STAGE_TIMEOUT_EN
  mem_stage_ctrl #(.TIMEOUT(8'd4)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
  mem_stage_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [15:0] addr;
    logic [15:0] sr;
    int          waits;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic [15:0] ea1;
    logic [15:0] ea2;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic [15:0] wb;
  } vec_t;

  vec_t        vecs[7];
  logic [15:0] sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.wb_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("wb_valid_unexpected", {16'h0, bus.wb_data}, 32'hFFFF_FFFF);
      end else begin
        chk("wb_data", {16'h0, bus.wb_data}, {16'h0, sb_q.pop_front()});
      end
    end
  end

  task automatic phase(input int waits, input logic [15:0] rdata, input logic exp_rd,
                       input logic exp_wr, input logic [15:0] exp_addr, input logic [1:0] exp_be,
                       input logic [15:0] exp_wdata, input logic is_final);
    for (int w = 0; w <= waits; w++) begin
      bus.dmem_resp  = (w == waits);
      bus.dmem_rdata = (w == waits) ? rdata : 16'h0000;
      @(negedge clk);
      chk("req", {bus.dmem_read, bus.dmem_write}, {exp_rd, exp_wr});
      chk("dmem_addr", bus.dmem_addr, exp_addr);
      chk("byte_enable", bus.dmem_byte_enable, exp_be);
      if (exp_wr) chk("dmem_wdata", bus.dmem_wdata, exp_wdata);
      chk("stall", bus.stall, !(is_final && w == waits));
      @(posedge clk); #1;
    end
    bus.dmem_resp = 1'b0;
  endtask

  task automatic present(input logic [3:0] op, input logic [15:0] addr, input logic [15:0] sr);
    bus.mem_valid      = 1'b1;
    bus.mem_ir         = {op, 12'h0A5};
    bus.mem_address    = addr;
    bus.mem_store_data = sr;
  endtask

  task automatic run_op(input vec_t v);
    logic ind, ld;
    ind = v.op[3];
    ld  = ~v.op[0];
    present(v.op, v.addr, v.sr);
    if (ld) sb_q.push_back(v.wb);
    @(negedge clk);
    chk("idle_stall", bus.stall, 1'b1);
    chk("idle_req", {bus.dmem_read, bus.dmem_write}, 2'b00);
    @(posedge clk); #1;
    if (ind) begin
      phase(v.waits, v.rd1, 1'b1, 1'b0, v.ea1, 2'b11, 16'h0, 1'b0);
      phase(v.waits, v.rd2, ld, ~ld, v.ea2, v.be, v.wdata, 1'b1);
    end else begin
      phase(v.waits, v.rd1, ld, ~ld, v.ea1, v.be, v.wdata, 1'b1);
    end
    bus.mem_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'b0110, 16'h1001, 16'h0000, 2, 16'hBEEF, 16'h0, 16'h1000, 16'h0, 2'b11, 16'h0, 16'hBEEF};
    vecs[1] = '{4'b0010, 16'h2003, 16'h0000, 0, 16'h807F, 16'h0, 16'h2003, 16'h0, 2'b10, 16'h0, 16'hFF80};
    vecs[2] = '{4'b0010, 16'h2002, 16'h0000, 1, 16'h807F, 16'h0, 16'h2002, 16'h0, 2'b01, 16'h0, 16'h007F};
    vecs[3] = '{4'b0011, 16'h3000, 16'h12AB, 0, 16'h0000, 16'h0, 16'h3000, 16'h0, 2'b01, 16'hABAB, 16'h0};
    vecs[4] = '{4'b1011, 16'h4000, 16'h1234, 1, 16'h5002, 16'h0, 16'h4000, 16'h5002, 2'b11, 16'h1234, 16'h0};
    vecs[5] = '{4'b1010, 16'h6003, 16'h0000, 0, 16'h7001, 16'hCAFE, 16'h6002, 16'h7000, 2'b11, 16'h0, 16'hCAFE};
    vecs[6] = '{4'b0111, 16'h8001, 16'h5A5A, 2, 16'h0000, 16'h0, 16'h8000, 16'h0, 2'b11, 16'h5A5A, 16'h0};

    reset = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_ir = 16'h0;
    bus.mem_address = 16'h0;
    bus.mem_store_data = 16'h0;
    bus.dmem_resp = 1'b0;
    bus.dmem_rdata = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {bus.dmem_read, bus.dmem_write}, 2'b00);
    chk("rst_be", bus.dmem_byte_enable, 2'b00);
    chk("rst_wb", {bus.wb_valid, bus.wb_data}, 17'h0);
    chk("rst_err_stall", {bus.mem_error, bus.stall}, 2'b00);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_op(vecs[i]);

    // Response while idle must be ignored.
    bus.dmem_resp  = 1'b1;
    bus.dmem_rdata = 16'h1111;
    @(negedge clk);
    chk("idle_resp_stall", bus.stall, 1'b0);
    @(posedge clk); #1;
    bus.dmem_resp = 1'b0;
    @(negedge clk);
    chk("idle_resp_req", {bus.dmem_read, bus.dmem_write}, 2'b00);
    @(posedge clk); #1;

    // Non-memory instruction passes without stall.
    present(4'b0001, 16'h1234, 16'h0);
    repeat (2) begin
      @(negedge clk);
      chk("add_stall", bus.stall, 1'b0);
      chk("add_req", {bus.dmem_read, bus.dmem_write}, 2'b00);
      @(posedge clk); #1;
    end
    bus.mem_valid = 1'b0;

    // Reset while LDI sits in its pointer-dereference access.
    present(4'b1010, 16'h6003, 16'h0);
    @(posedge clk); #1;
    bus.dmem_resp  = 1'b1;
    bus.dmem_rdata = 16'h7001;
    @(posedge clk); #1;
    bus.dmem_resp = 1'b0;
    @(negedge clk);
    chk("ldi_ind_read", {bus.dmem_read, bus.dmem_addr}, {1'b1, 16'h7000});
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_req", {bus.dmem_read, bus.dmem_write, bus.dmem_byte_enable}, 4'b0000);
    chk("rst_mid_wb_valid", bus.wb_valid, 1'b0);
    chk("rst_mid_stall", bus.stall, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(vecs[5]);

`ifdef MEM_STAGE_TIMEOUT_EN
    present(4'b0110, 16'h1000, 16'h0);
    sb_q.push_back(16'h0000);
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("to_read_held", {bus.dmem_read, bus.stall}, 2'b11);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("to_read_drop", {bus.dmem_read, bus.stall}, 2'b00);
    @(posedge clk); #1;
    present(4'b0001, 16'h0, 16'h0);
    @(negedge clk);
    chk("to_add_stall", bus.stall, 1'b0);
    chk("to_mem_error", bus.mem_error, 1'b1);
    @(posedge clk); #1;
    bus.mem_valid = 1'b0;
`else
    chk("mem_error_tied", bus.mem_error, 1'b0);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
